dcache_port_arbiter: RTL

Shares the single D-cache request port between the core load/store path and the MMU page-table walker. Grants one requester at a time and holds ownership until that transaction's response returns. Steers the response back to the owner. The walker has priority; a starvation counter bounds how long a pending core request can wait. The arbiter sits between the LSU, the MMU's D-cache takeover interface and the D-cache.

---
 rtl/dcache_arb_pkg.sv | 13 +
 rtl/dcache_port_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/dcache_arb_pkg.sv
// Shared types and widths for the D-cache port arbiter.
package dcache_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CORE = 2'd1,
    ARB_WALK = 2'd2
  } arb_state_t;

  localparam int DC_ADDR_W = 64;
  localparam int DC_DATA_W = 64;

endpackage

// File: rtl/dcache_port_arbiter.sv
// D-cache port arbiter: shares one D-cache request port between the core
// LSU and the MMU page-table walker. One transaction outstanding at most;
// the walker has priority unless the core has been starved STARVE_LIMIT
// consecutive walker grants.
//
// Handshake: a request transfers on a cycle where dc_req_valid && dc_req_ready.
// The core holds core_req_valid and payload until core_req_ready; the walker
// may be replaced or re-selected every cycle until accepted. Responses are
// single-cycle pulses with no back-pressure.
module dcache_port_arbiter
  import dcache_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 core_req_valid,
  input  logic [DC_ADDR_W-1:0] core_req_addr,
  input  logic                 core_req_write,
  input  logic [DC_DATA_W-1:0] core_req_wdata,
  input  logic [7:0]           core_req_wstrb,
  output logic                 core_req_ready,
  output logic                 core_resp_valid,
  output logic [DC_DATA_W-1:0] core_resp_data,
  input  logic                 walk_req_valid,
  input  logic [DC_ADDR_W-1:0] walk_req_addr,
  output logic                 walk_resp_valid,
  output logic [DC_DATA_W-1:0] walk_resp_data,
  output logic                 dc_req_valid,
  input  logic                 dc_req_ready,
  output logic [DC_ADDR_W-1:0] dc_req_addr,
  output logic                 dc_req_write,
  output logic [DC_DATA_W-1:0] dc_req_wdata,
  output logic [7:0]           dc_req_wstrb,
  output logic                 dc_req_phys,
  input  logic                 dc_resp_valid,
  input  logic [DC_DATA_W-1:0] dc_resp_data,
  output logic                 err_spurious
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             err_q, err_d;
  logic             core_sel, walk_sel;

  // State, starvation counter and sticky error register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      starve_cnt_q <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      err_q        <= err_d;
    end
  end

  // Selection, request mux, response steering and next-state logic.
  always_comb begin
    state_d         = state_q;
    starve_cnt_d    = starve_cnt_q;
    err_d           = err_q;
    core_sel        = 1'b0;
    walk_sel        = 1'b0;
    core_req_ready  = 1'b0;
    core_resp_valid = 1'b0;
    core_resp_data  = '0;
    walk_resp_valid = 1'b0;
    walk_resp_data  = '0;
    dc_req_valid    = 1'b0;
    dc_req_addr     = '0;
    dc_req_write    = 1'b0;
    dc_req_wdata    = '0;
    dc_req_wstrb    = '0;
    dc_req_phys     = 1'b0;
    err_spurious    = err_q;

    case (state_q)
      ARB_IDLE: begin
        core_sel = core_req_valid && (!walk_req_valid || starve_cnt_q == LIMIT_C);
        walk_sel = walk_req_valid && !core_sel;
        if (core_sel) begin
          dc_req_valid = 1'b1;
          dc_req_addr  = core_req_addr;
          dc_req_write = core_req_write;
          dc_req_wdata = core_req_wdata;
          dc_req_wstrb = core_req_wstrb;
          if (dc_req_ready) begin
            core_req_ready = 1'b1;
            state_d        = ARB_CORE;
            starve_cnt_d   = '0;
          end
        end else if (walk_sel) begin
          dc_req_valid = 1'b1;
          dc_req_addr  = walk_req_addr;
          dc_req_phys  = 1'b1;
          if (dc_req_ready) begin
            state_d = ARB_WALK;
            if (core_req_valid && starve_cnt_q != LIMIT_C) begin
              starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
          end
        end
        // Nothing is outstanding, so any response here is unexpected.
        if (dc_resp_valid) begin
          err_d = 1'b1;
        end
      end
      ARB_CORE: begin
        if (dc_resp_valid) begin
          core_resp_valid = 1'b1;
          core_resp_data  = dc_resp_data;
          state_d         = ARB_IDLE;
        end
      end
      ARB_WALK: begin
        dc_req_phys = 1'b1;
        if (dc_resp_valid) begin
          walk_resp_valid = 1'b1;
          walk_resp_data  = dc_resp_data;
          state_d         = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    // All outputs are held quiet while reset is asserted.
    if (reset) begin
      core_req_ready  = 1'b0;
      core_resp_valid = 1'b0;
      core_resp_data  = '0;
      walk_resp_valid = 1'b0;
      walk_resp_data  = '0;
      dc_req_valid    = 1'b0;
      dc_req_addr     = '0;
      dc_req_write    = 1'b0;
      dc_req_wdata    = '0;
      dc_req_wstrb    = '0;
      dc_req_phys     = 1'b0;
      err_spurious    = 1'b0;
    end
  end

endmodule
